// File: rtl/fullsub_serial_46.sv
// fullsub_serial_46
// Digit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), computed DIGIT
// bits per clock through a DIGIT-wide ripple-borrow slice. One operation
// takes N = WIDTH/DIGIT RUN cycles.
//
// Handshake (valid/ready style): start is the request and is only looked at
// while busy is low (state IDLE). The edge that sees start=1 in IDLE accepts
// the operands. busy is high for the N cycles that follow that edge. At the
// N-th edge the results load, busy drops, and done pulses for one cycle.
// start seen while busy is ignored, and nothing is queued.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow into bit 0, captured on an accepted start
//   busy   operation in progress
//   done   one-cycle pulse, result registers freshly loaded
//   diff   a - b - bin mod 2^WIDTH, held until the next completion
//   borr   borrow out of the MSB (unsigned a < b + bin)
//   ovf    signed overflow (borrow into MSB xor borrow out of MSB)
module fullsub_serial_46 #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borr,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("fullsub_serial_46: DIGIT must be >= 1 and divide WIDTH");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [DIGIT-1:0] sd;
   logic [DIGIT:0]   chain;

   assign busy = (state == RUN);
   assign last = (cnt == CW'(N - 1));

   // Ripple-borrow slice over the low DIGIT bits of the shifted operands.
   // chain[i] is the borrow into bit i of the slice.
   always_comb begin
      sd       = '0;
      chain    = '0;
      chain[0] = brw;
      for (int i = 0; i < DIGIT; i++) begin
         sd[i]      = a_sh[i] ^ b_sh[i] ^ chain[i];
         chain[i+1] = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & chain[i]);
      end
   end

   // New diff digits enter from the MSB side, so after N shifts the first
   // digit computed ends up at bit 0.
   always_comb begin
      res_nx = (res_sh >> DIGIT) | (WIDTH'(sd) << (WIDTH - DIGIT));
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         diff   <= '0;
         borr   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  brw  <= bin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               brw    <= chain[DIGIT];
               res_sh <= res_nx;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  // In the final digit the top slice bit is the word MSB, so
                  // chain[DIGIT-1] is the borrow into the MSB.
                  diff <= res_nx;
                  borr <= chain[DIGIT];
                  ovf  <= chain[DIGIT-1] ^ chain[DIGIT];
                  done <= 1'b1;
                  cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fullsub_serial_46.sv
// Bench for fullsub_serial_46. Three instances share clock and reset:
//   k=0: WIDTH=8, DIGIT=1   k=1: WIDTH=1, DIGIT=1   k=2: WIDTH=8, DIGIT=4
// Inputs are driven and outputs sampled on the falling edge.
module tb_fullsub_serial_46;

   localparam int NW[3] = '{8, 1, 8};
   localparam int ND[3] = '{1, 1, 4};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start_v, bin_v;
   logic [7:0] a_v[3], b_v[3];
   wire  [2:0] busy_v, done_v, borr_v, ovf_v;
   wire  [7:0] diff0, diff2;
   wire        diff1_w;

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q[$];
   logic [9:0] last_res[3];

   // clock
   always #5 clk = ~clk;

   fullsub_serial_46 #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .bin(bin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .diff(diff0),
      .borr(borr_v[0]), .ovf(ovf_v[0]));

   fullsub_serial_46 #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
      .bin(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(diff1_w),
      .borr(borr_v[1]), .ovf(ovf_v[1]));

   fullsub_serial_46 #(.WIDTH(8), .DIGIT(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
      .bin(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .diff(diff2),
      .borr(borr_v[2]), .ovf(ovf_v[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values. Returns {ovf, borr, diff}.
   function automatic logic [9:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                        input logic bi);
      int mask, ua, ub, r, sa, sb, sr;
      logic [7:0] d;
      logic bo, ov;
      mask = (1 << w) - 1;
      ua   = int'(av) & mask;
      ub   = int'(bv) & mask;
      r    = ua - ub - int'(bi);
      d    = 8'(r & mask);
      bo   = (r < 0);
      sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      sr   = sa - sb - int'(bi);
      ov   = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
      return {ov, bo, d};
   endfunction

   function automatic logic [9:0] obs(input int k);
      case (k)
         0:       return {ovf_v[0], borr_v[0], diff0};
         1:       return {ovf_v[1], borr_v[1], 7'b0, diff1_w};
         default: return {ovf_v[2], borr_v[2], diff2};
      endcase
   endfunction

   // One operation on instance k. Called at a falling edge with the instance
   // idle. junk=1 wiggles operands and start while busy. hold=1 returns in
   // the done cycle so the caller can issue a back-to-back start.
   task automatic op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     input bit junk, input bit hold);
      logic [9:0] exp;
      int lat;
      int n;
      n = NW[k] / ND[k];
      exp_q.push_back(model(NW[k], av, bv, bi));
      a_v[k] = av; b_v[k] = bv; bin_v[k] = bi; start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      lat = 0;
      while (!done_v[k] && lat < 40) begin
         chk($sformatf("busy_run%0d", k), busy_v[k], 1);
         chk($sformatf("hold_run%0d", k), obs(k), last_res[k]);
         if (junk) begin
            a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
            bin_v[k] = 1'($urandom); start_v[k] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      start_v[k] = 1'b0;
      chk($sformatf("latency%0d", k), lat, n);
      chk($sformatf("busy_done%0d", k), busy_v[k], 0);
      exp = exp_q.pop_front();
      chk($sformatf("diff%0d", k), obs(k) & 10'h0ff, exp & 10'h0ff);
      chk($sformatf("borr%0d", k), obs(k) >> 8 & 1, exp >> 8 & 1);
      chk($sformatf("ovf%0d", k), obs(k) >> 9, exp >> 9);
      last_res[k] = exp;
      if (!hold) begin
         @(negedge clk);
         chk($sformatf("done_pulse%0d", k), done_v[k], 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_v = '0; bin_v = '0;
      for (int k = 0; k < 3; k++) begin
         a_v[k] = '0; b_v[k] = '0; last_res[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy", busy_v[k], 0);
         chk("rst_done", done_v[k], 0);
         chk("rst_res", obs(k), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // WIDTH=1 truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         op(1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, 1'b0);
      end

      // WIDTH=8, DIGIT=1 directed
      op(0, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
      op(0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      op(0, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
      op(0, 8'h5A, 8'h33, 1'b1, 1'b1, 1'b1);   // junk during RUN, then back-to-back
      op(0, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0);

      // WIDTH=8, DIGIT=4 directed
      op(2, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);

      // random
      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < 3; k++) begin
            op(k, 8'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      @(negedge clk);

      // Reset mid-RUN: leave a non-zero result first
      op(0, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0);
      a_v[0] = 8'h33; b_v[0] = 8'h11; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy_v[0], 0);
      chk("abort_done", done_v[0], 0);
      chk("abort_res", obs(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("post_rst_done", done_v[0], 0);
         chk("post_rst_busy", busy_v[0], 0);
         chk("post_rst_res", obs(0), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
